sram_scan_reader: RTL

- Autonomous read-back sequencer for the 16x4 single-port block-RAM (mem_gen) filled by the manual write/read FSM.
- On a button press it walks every address 0..15 and shows each word on the LEDs for a fixed hold time, with the address shown alongside.
- It is the bulk reader for the manual writer.
- It drives the RAM's a-port (ena/wea/addra) and consumes douta.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_scan_reader_if.sv | 35 +++
 rtl/btn_in.sv | 51 +++++
 rtl/sram_scan_reader.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared encodings and defaults for the RAM scan reader
//
// Contents:
//   scan_state_t          FSM state encoding (IDLE, REQ, CAPT, HOLD)
//   ADDR_W_DEF            default RAM address width (depth is 2**ADDR_W)
//   DATA_W_DEF            default RAM word width
//   HOLD_CYCLES_DEF       default display time per word, in clock cycles
//   DEBOUNCE_CYCLES_DEF   default settle time of the push-button debouncer
package sram_pkg;

   localparam int ADDR_W_DEF          = 4;
   localparam int DATA_W_DEF          = 4;
   localparam int HOLD_CYCLES_DEF     = 25_000_000;
   localparam int DEBOUNCE_CYCLES_DEF = 250_000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CAPT = 2'd2,
      HOLD = 2'd3
   } scan_state_t;

endpackage

// File: rtl/sram_scan_reader_if.sv
// rtl/sram_scan_reader_if.sv - single-port RAM a-port bundle
//
// Signals:
//   mem_ena    RAM enable
//   mem_wea    RAM write enable
//   mem_addr   RAM address (ADDR_W bits)
//   mem_rdata  RAM read data (DATA_W bits), valid one cycle after an enabled address
// Modports:
//   master  the sequencer driving the RAM
//   slave   the RAM itself
interface sram_scan_reader_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
);

   logic              mem_ena;
   logic              mem_wea;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_ena,
      output mem_wea,
      output mem_addr,
      input  mem_rdata
   );

   modport slave (
      input  mem_ena,
      input  mem_wea,
      input  mem_addr,
      output mem_rdata
   );

endinterface

// File: rtl/btn_in.sv
// rtl/btn_in.sv - push-button synchroniser and debouncer with one-cycle press pulse
//
// Ports:
//   clock     system clock, rising edge
//   n_reset   asynchronous active-low reset
//   btn_in    raw push-button level
//   btn_out   registered single-cycle pulse on each debounced 0->1 transition
// Parameter:
//   DEBOUNCE_CYCLES  cycles the synchronised level must stay changed before it is accepted (>= 1)
module btn_in #(
   parameter int DEBOUNCE_CYCLES = 250_000
) (
   input  logic clock,
   input  logic n_reset,
   input  logic btn_in,
   output logic btn_out
);

   localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync0;
   logic             sync1;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         sync0   <= 1'b0;
         sync1   <= 1'b0;
         stable  <= 1'b0;
         cnt     <= '0;
         btn_out <= 1'b0;
      end else begin
         sync0   <= btn_in;
         sync1   <= sync0;
         btn_out <= 1'b0;
         // Any bounce back to the accepted level restarts the settle window.
         if (sync1 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            stable  <= sync1;
            btn_out <= sync1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_scan_reader.sv
// rtl/sram_scan_reader.sv - walks every RAM address on a button press and displays each word
//
// Ports:
//   clock      system clock, rising edge
//   n_reset    asynchronous active-low reset
//   btn        raw push-button, debounced by btn_in
//   mem        RAM a-port (master): mem_ena, mem_wea (always 0), mem_addr out; mem_rdata in
//   led        displayed word
//   addr_led   address of the displayed word
//   busy       high while a scan is active
// Build option:
//   SRAM_SCAN_LOOP_EN  when defined, the scan wraps from the last address back to 0
//                      and keeps running until a press or reset; otherwise it stops in IDLE.
module sram_scan_reader
   import sram_pkg::*;
#(
   parameter int ADDR_W          = ADDR_W_DEF,
   parameter int DATA_W          = DATA_W_DEF,
   parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                clock,
   input  logic                n_reset,
   input  logic                btn,
   sram_scan_reader_if.master  mem,
   output logic [DATA_W-1:0]   led,
   output logic [ADDR_W-1:0]   addr_led,
   output logic                busy
);

   localparam int               CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

`ifdef SRAM_SCAN_LOOP_EN
   localparam scan_state_t END_STATE = REQ;
`else
   localparam scan_state_t END_STATE = IDLE;
`endif

   scan_state_t       state;
   scan_state_t       state_nxt;
   logic              press;
   logic [ADDR_W-1:0] scan_addr;
   logic [CNT_W-1:0]  hold_cnt;
   logic              hold_done;
   logic              last_addr;

   btn_in #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_in (
      .clock   (clock),
      .n_reset (n_reset),
      .btn_in  (btn),
      .btn_out (press)
   );

   assign hold_done = (hold_cnt == HOLD_LAST);
   assign last_addr = (scan_addr == {ADDR_W{1'b1}});

   assign mem.mem_wea  = 1'b0;
   assign mem.mem_addr = scan_addr;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A press while scanning always aborts, even on the cycle the hold expires.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (press) state_nxt = REQ;
         REQ:  state_nxt = press ? IDLE : CAPT;
         CAPT: state_nxt = press ? IDLE : HOLD;
         HOLD: begin
            if (press) begin
               state_nxt = IDLE;
            end else if (hold_done) begin
               state_nxt = last_addr ? END_STATE : REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != IDLE);
      mem.mem_ena = (state == REQ);
   end

   // Display, scan address and hold counter. Updates are suppressed on an
   // abort so the last shown word and address stay on the LEDs.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         scan_addr <= '0;
         hold_cnt  <= '0;
         led       <= '0;
         addr_led  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (press) begin
                  scan_addr <= '0;
                  led       <= '0;
                  addr_led  <= '0;
               end
            end
            CAPT: begin
               if (!press) begin
                  led      <= mem.mem_rdata;
                  addr_led <= scan_addr;
                  hold_cnt <= '0;
               end
            end
            HOLD: begin
               if (!press) begin
                  if (hold_done) begin
                     hold_cnt <= '0;
                     if (!last_addr) begin
                        scan_addr <= scan_addr + 1'b1;
                     end else begin
`ifdef SRAM_SCAN_LOOP_EN
                        scan_addr <= '0;
`else
                        scan_addr <= scan_addr;
`endif
                     end
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
